tick_scheduler: RTL

Multi-channel timer scheduler driven by the shared one-clock-wide base tick from the system tick generator. Each of NCH channels holds a programmable period, counted in base ticks, and a mode (one-shot or periodic). When its count expires, the channel emits a one-clock pulse. Controllers configure channels through a single-cycle write port, which avoids a divider instance per consumer.

---
 rtl/tick_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Multi-channel base-tick timer: NCH channels with programmable period and one-shot/periodic mode.
// Optional sticky expiry interrupt enabled by defining TICK_SCHED_IRQ_EN.
module tick_sched_ch #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_in,
  input  logic          we_i,
  input  logic          stop_i,
  input  logic [CW-1:0] period_i,
  input  logic          periodic_i,
  output logic          expire_o,
  output logic          tick_o,
  output logic          busy_o
);
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          periodic_q, periodic_d;
  logic          armed_q, armed_d;
  logic          tick_q, tick_d;

  // A command to this channel swallows a coincident tick.
  always_comb begin
    period_d   = period_q;
    rem_d      = rem_q;
    periodic_d = periodic_q;
    armed_d    = armed_q;
    tick_d     = 1'b0;
    if (stop_i) begin
      armed_d = 1'b0;
      rem_d   = '0;
    end else if (we_i) begin
      period_d   = period_i;
      rem_d      = period_i;
      periodic_d = periodic_i;
      armed_d    = 1'b1;
    end else if (armed_q && tick_in) begin
      if (rem_q > CW'(1)) begin
        rem_d = rem_q - CW'(1);
      end else begin
        tick_d = 1'b1;
        if (periodic_q) begin
          rem_d = period_q;
        end else begin
          armed_d = 1'b0;
          rem_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q   <= '0;
      rem_q      <= '0;
      periodic_q <= 1'b0;
      armed_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      period_q   <= period_d;
      rem_q      <= rem_d;
      periodic_q <= periodic_d;
      armed_q    <= armed_d;
      tick_q     <= tick_d;
    end
  end

  assign expire_o = tick_d;
  assign tick_o   = tick_q;
  assign busy_o   = armed_q;
endmodule

module tick_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset_n,
  input  logic                   tick_in,
  input  logic                   cfg_we,
  input  logic                   cfg_stop,
  input  logic [$clog2(NCH)-1:0] cfg_addr,
  input  logic [CW-1:0]          cfg_period,
  input  logic                   cfg_periodic,
  output logic                   cfg_err,
  output logic [NCH-1:0]         ch_tick,
  output logic [NCH-1:0]         ch_busy,
  output logic                   irq,
  output logic [NCH-1:0]         irq_pending,
  input  logic [NCH-1:0]         irq_ack
);
  localparam int AW = $clog2(NCH);

  logic           addr_ok, we_ok, stop_ok;
  logic           cfg_err_q, cfg_err_d;
  logic [NCH-1:0] expire;

  // Stop takes priority over a simultaneous write; the write is then reported.
  always_comb begin
    addr_ok   = ({1'b0, cfg_addr} < (AW+1)'(NCH));
    stop_ok   = cfg_stop && addr_ok;
    we_ok     = cfg_we && !cfg_stop && addr_ok && (cfg_period != '0);
    cfg_err_d = (cfg_we && !we_ok) || (cfg_stop && !addr_ok);
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) cfg_err_q <= 1'b0;
    else              cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_sched_ch #(.CW(CW)) u_ch (
      .clk        (sys_clk),
      .rst_n      (sys_reset_n),
      .tick_in    (tick_in),
      .we_i       (we_ok && (cfg_addr == AW'(i))),
      .stop_i     (stop_ok && (cfg_addr == AW'(i))),
      .period_i   (cfg_period),
      .periodic_i (cfg_periodic),
      .expire_o   (expire[i]),
      .tick_o     (ch_tick[i]),
      .busy_o     (ch_busy[i])
    );
  end

`ifdef TICK_SCHED_IRQ_EN
  logic [NCH-1:0] pend_q, pend_d;
  logic           irq_q, irq_d;

  // Pending bits set alongside ch_tick; a same-cycle set beats the ack.
  always_comb begin
    pend_d = (pend_q & ~irq_ack) | expire;
    irq_d  = |pend_q;
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_pending = pend_q;
  assign irq         = irq_q;
`else
  logic unused_irq_in;
  assign unused_irq_in = ^{irq_ack, expire};
  assign irq_pending   = '0;
  assign irq           = 1'b0;
`endif
endmodule
